// File: rtl/sc_movescheduler_pkg.sv
// sc_movescheduler_pkg: shared types for the move scheduler.
//   - state_e    : sequencer states (idle, run, one-cycle command, hold).
//   - cmd_e      : datapath command chosen for the next cycle.
//   - dp_cmd_t   : registered datapath control bundle (active-low strobes, shift code, landed).
//   - decode_cmd : maps a command to its datapath control bundle.
package sc_movescheduler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCmd,
        StHold
    } state_e;

    typedef enum logic [2:0] {
        CmdNone,
        CmdClear,
        CmdUp,
        CmdDown,
        CmdLeft,
        CmdRight,
        CmdFall
    } cmd_e;

    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    typedef struct packed {
        logic       clear_n;
        logic       load0_n;
        logic       load1_n;
        logic [1:0] shift;
        logic       landed;
    } dp_cmd_t;

    localparam dp_cmd_t DP_IDLE = '{
        clear_n: 1'b1,
        load0_n: 1'b1,
        load1_n: 1'b1,
        shift:   SHIFT_HOLD,
        landed:  1'b0
    };

    // not_bottom is the raw comparator level: 1 means the point can still fall.
    function automatic dp_cmd_t decode_cmd(cmd_e cmd, logic not_bottom);
        dp_cmd_t o;
        o = DP_IDLE;
        case (cmd)
            CmdClear: o.clear_n = 1'b0;
            CmdUp:    o.load0_n = 1'b0;
            CmdDown:  o.load1_n = 1'b0;
            CmdLeft:  o.shift   = SHIFT_LEFT;
            CmdRight: o.shift   = SHIFT_RIGHT;
            CmdFall: begin
                if (not_bottom) begin
                    o.load1_n = 1'b0;
                end else begin
                    o.landed = 1'b1;
                end
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sc_movescheduler_if.sv
// sc_movescheduler_if: button-side requests and datapath commands of the move scheduler.
//   slave  modport : the scheduler (samples buttons, drives commands).
//   master modport : the button/datapath environment (drives buttons, samples commands).
// All button inputs are active-low levels; command strobes are active-low single-cycle pulses.
interface sc_movescheduler_if;
    logic       SC_MOVESCHEDULER_startButton_InLow;
    logic       SC_MOVESCHEDULER_upButton_InLow;
    logic       SC_MOVESCHEDULER_downButton_InLow;
    logic       SC_MOVESCHEDULER_leftButton_InLow;
    logic       SC_MOVESCHEDULER_rightButton_InLow;
    logic       SC_MOVESCHEDULER_bottomsidecomparator_InLow;
    logic       SC_MOVESCHEDULER_clear_OutLow;
    logic       SC_MOVESCHEDULER_load0_OutLow;
    logic       SC_MOVESCHEDULER_load1_OutLow;
    logic [1:0] SC_MOVESCHEDULER_shiftselection_Out;
    logic       SC_MOVESCHEDULER_landed_OutHigh;

    modport slave (
        input  SC_MOVESCHEDULER_startButton_InLow,
        input  SC_MOVESCHEDULER_upButton_InLow,
        input  SC_MOVESCHEDULER_downButton_InLow,
        input  SC_MOVESCHEDULER_leftButton_InLow,
        input  SC_MOVESCHEDULER_rightButton_InLow,
        input  SC_MOVESCHEDULER_bottomsidecomparator_InLow,
        output SC_MOVESCHEDULER_clear_OutLow,
        output SC_MOVESCHEDULER_load0_OutLow,
        output SC_MOVESCHEDULER_load1_OutLow,
        output SC_MOVESCHEDULER_shiftselection_Out,
        output SC_MOVESCHEDULER_landed_OutHigh
    );

    modport master (
        output SC_MOVESCHEDULER_startButton_InLow,
        output SC_MOVESCHEDULER_upButton_InLow,
        output SC_MOVESCHEDULER_downButton_InLow,
        output SC_MOVESCHEDULER_leftButton_InLow,
        output SC_MOVESCHEDULER_rightButton_InLow,
        output SC_MOVESCHEDULER_bottomsidecomparator_InLow,
        input  SC_MOVESCHEDULER_clear_OutLow,
        input  SC_MOVESCHEDULER_load0_OutLow,
        input  SC_MOVESCHEDULER_load1_OutLow,
        input  SC_MOVESCHEDULER_shiftselection_Out,
        input  SC_MOVESCHEDULER_landed_OutHigh
    );
endinterface

// File: rtl/sc_movescheduler_ticker.sv
// sc_movescheduler_ticker: modulo-Period counter with a sticky pending flag.
//   clk_i      : clock.
//   rst_i      : synchronous active-high reset (counter 0, pending 0).
//   en_i       : count enable.
//   clr_i      : synchronous counter clear; suppresses the tick in the same cycle.
//   pend_clr_i : clear request for the pending flag (a simultaneous tick wins).
//   tick_o     : high in the cycle the counter wraps from Period-1 to 0.
//   pend_o     : sticky pending flag set by tick_o.
module sc_movescheduler_ticker #(
    parameter int unsigned Period = 8,
    parameter int unsigned CntW   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic pend_clr_i,
    output logic tick_o,
    output logic pend_o
);
    localparam logic [CntW-1:0] Last = CntW'(Period - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;

    always_comb begin
        tick_o = en_i && !clr_i && (cnt_q == Last);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
        // Set wins so a tick coinciding with consumption is never lost.
        pend_d = tick_o ? 1'b1 : (pend_clr_i ? 1'b0 : pend_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/sc_movescheduler.sv
// sc_movescheduler: turns active-low button levels and a gravity timer into single-cycle,
// mutually exclusive point-datapath commands (clear / up / down / left / right / fall).
//   SC_MOVESCHEDULER_CLOCK_50     : system clock.
//   SC_MOVESCHEDULER_RESET_InHigh : synchronous active-high reset.
//   sched_io (slave modport)      : buttons, bottom-row comparator, registered commands.
// Optional build macro SC_MOVESCHEDULER_AUTOREPEAT_EN: held down/left/right moves repeat
// every REPEAT_DELAY cycles of HOLD; without it HOLD only waits for gravity or release.
module sc_movescheduler
    import sc_movescheduler_pkg::*;
#(
    parameter int unsigned FALL_PERIOD  = 25000000,
    parameter int unsigned REPEAT_DELAY = 12500000,
    parameter int unsigned CNT_W        = 25
) (
    input logic               SC_MOVESCHEDULER_CLOCK_50,
    input logic               SC_MOVESCHEDULER_RESET_InHigh,
    sc_movescheduler_if.slave sched_io
);
    logic clk, rst;
    assign clk = SC_MOVESCHEDULER_CLOCK_50;
    assign rst = SC_MOVESCHEDULER_RESET_InHigh;

    logic start_p, up_p, down_p, left_p, right_p, not_bottom, any_btn;
    assign start_p    = ~sched_io.SC_MOVESCHEDULER_startButton_InLow;
    assign up_p       = ~sched_io.SC_MOVESCHEDULER_upButton_InLow;
    assign down_p     = ~sched_io.SC_MOVESCHEDULER_downButton_InLow;
    assign left_p     = ~sched_io.SC_MOVESCHEDULER_leftButton_InLow;
    assign right_p    = ~sched_io.SC_MOVESCHEDULER_rightButton_InLow;
    assign not_bottom = sched_io.SC_MOVESCHEDULER_bottomsidecomparator_InLow;
    assign any_btn    = start_p | up_p | down_p | left_p | right_p;

    state_e  state_q, state_d;
    cmd_e    cmd_d;
    dp_cmd_t out_q, out_d;

    logic fall_pend, fall_clr, fall_pend_clr, fall_tick_unused;

    // Gravity timer: held at 0 while idle, restarted by CLEAR and by a user DOWN.
    sc_movescheduler_ticker #(
        .Period (FALL_PERIOD),
        .CntW   (CNT_W)
    ) u_fall_ticker (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (state_q != StIdle),
        .clr_i      (fall_clr),
        .pend_clr_i (fall_pend_clr),
        .tick_o     (fall_tick_unused),
        .pend_o     (fall_pend)
    );

`ifdef SC_MOVESCHEDULER_AUTOREPEAT_EN
    logic rep_tick, rep_pend_unused;

    // Counts only in HOLD, so any command (repeat or fall) restarts it from 0.
    sc_movescheduler_ticker #(
        .Period (REPEAT_DELAY),
        .CntW   (CNT_W)
    ) u_repeat_ticker (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (state_q == StHold),
        .clr_i      (state_q != StHold),
        .pend_clr_i (1'b1),
        .tick_o     (rep_tick),
        .pend_o     (rep_pend_unused)
    );
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = CmdNone;

        unique case (state_q)
            StIdle: begin
                if (start_p) cmd_d = CmdClear;
            end
            StRun: begin
                if (start_p)                  cmd_d = CmdClear;
                else if (fall_pend)           cmd_d = CmdFall;
                else if (up_p)                cmd_d = CmdUp;
                else if (down_p && not_bottom) cmd_d = CmdDown;
                else if (left_p)              cmd_d = CmdLeft;
                else if (right_p)             cmd_d = CmdRight;
            end
            StCmd: begin
                state_d = any_btn ? StHold : StRun;
            end
            StHold: begin
                if (fall_pend) begin
                    cmd_d = CmdFall;
                end else if (!any_btn) begin
                    state_d = StRun;
                end
`ifdef SC_MOVESCHEDULER_AUTOREPEAT_EN
                // start and up are never repeated; they wait for release.
                else if (rep_tick) begin
                    if (down_p && not_bottom) cmd_d = CmdDown;
                    else if (left_p)          cmd_d = CmdLeft;
                    else if (right_p)         cmd_d = CmdRight;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        if (cmd_d != CmdNone) state_d = StCmd;

        fall_clr      = (state_q == StIdle) || (cmd_d == CmdClear) || (cmd_d == CmdDown);
        fall_pend_clr = (cmd_d == CmdFall);
        out_d         = decode_cmd(cmd_d, not_bottom);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= DP_IDLE;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign sched_io.SC_MOVESCHEDULER_clear_OutLow       = out_q.clear_n;
    assign sched_io.SC_MOVESCHEDULER_load0_OutLow       = out_q.load0_n;
    assign sched_io.SC_MOVESCHEDULER_load1_OutLow       = out_q.load1_n;
    assign sched_io.SC_MOVESCHEDULER_shiftselection_Out = out_q.shift;
    assign sched_io.SC_MOVESCHEDULER_landed_OutHigh     = out_q.landed;

endmodule

// File: tb/tb_sc_movescheduler.sv
// tb_sc_movescheduler: directed, table-driven bench for sc_movescheduler with
// FALL_PERIOD=8, REPEAT_DELAY=4. One table row per clock; outputs sampled 1 time unit
// after the rising edge. Rows carry the expected result for both build variants.
module tb_sc_movescheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sc_movescheduler_if bus ();

    sc_movescheduler #(
        .FALL_PERIOD  (8),
        .REPEAT_DELAY (4),
        .CNT_W        (4)
    ) dut (
        .SC_MOVESCHEDULER_CLOCK_50     (clk),
        .SC_MOVESCHEDULER_RESET_InHigh (rst),
        .sched_io                      (bus)
    );

    // Expected-output codes.
    localparam int EI = 0;  // idle
    localparam int EC = 1;  // clear
    localparam int EU = 2;  // up (load0)
    localparam int ED = 3;  // down or fall (load1)
    localparam int EL = 4;  // left
    localparam int ER = 5;  // right
    localparam int EG = 6;  // landed

    typedef struct {
        logic       rst;
        logic [4:0] btn;   // {start, up, down, left, right}, active low
        logic       bot;   // bottomside comparator level
        int         exp;   // expectation without auto-repeat
        int         exp_rep; // expectation with auto-repeat
    } vec_t;

    localparam int NVEC = 80;
    vec_t tbl [NVEC];

    int n_pass  = 0;
    int n_total = 0;

    // {clear, load0, load1, shift[1:0], landed}
    function automatic logic [5:0] want_of(int e);
        case (e)
            EC:      return 6'b011110;
            EU:      return 6'b101110;
            ED:      return 6'b110110;
            EL:      return 6'b111010;
            ER:      return 6'b111100;
            EG:      return 6'b111111;
            default: return 6'b111110;
        endcase
    endfunction

    function automatic logic [5:0] got_now();
        return {bus.SC_MOVESCHEDULER_clear_OutLow, bus.SC_MOVESCHEDULER_load0_OutLow,
                bus.SC_MOVESCHEDULER_load1_OutLow, bus.SC_MOVESCHEDULER_shiftselection_Out,
                bus.SC_MOVESCHEDULER_landed_OutHigh};
    endfunction

    task automatic set_row(input int i, input logic r, input logic [4:0] b, input logic bt,
                           input int e, input int er);
        tbl[i].rst     = r;
        tbl[i].btn     = b;
        tbl[i].bot     = bt;
        tbl[i].exp     = e;
        tbl[i].exp_rep = er;
    endtask

    task automatic step(input logic r, input logic [4:0] b, input logic bt);
        rst = r;
        bus.SC_MOVESCHEDULER_startButton_InLow          = b[4];
        bus.SC_MOVESCHEDULER_upButton_InLow             = b[3];
        bus.SC_MOVESCHEDULER_downButton_InLow           = b[2];
        bus.SC_MOVESCHEDULER_leftButton_InLow           = b[1];
        bus.SC_MOVESCHEDULER_rightButton_InLow          = b[0];
        bus.SC_MOVESCHEDULER_bottomsidecomparator_InLow = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [5:0] want);
        logic [5:0] got;
        got = got_now();
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {clr,ld0,ld1,sh,land}=%b required %b (t=%0t)",
                     name, got, want, $time);
        end
    endtask

    initial begin
        int e;
        for (int i = 0; i < NVEC; i++) set_row(i, 1'b0, 5'b11111, 1'b1, EI, EI);

        set_row(0,  1'b1, 5'b11111, 1'b1, EI, EI);   // reset state
        set_row(1,  1'b0, 5'b01111, 1'b1, EC, EC);   // start -> clear next cycle
        set_row(10, 1'b0, 5'b11111, 1'b1, ED, ED);   // first gravity fall
        for (int i = 12; i <= 18; i++) set_row(i, 1'b0, 5'b10111, 1'b1, EI, EI);
        set_row(12, 1'b0, 5'b10111, 1'b1, EU, EU);   // up once, never repeats
        set_row(18, 1'b0, 5'b10111, 1'b1, ED, ED);   // fall taken from HOLD
        for (int i = 26; i <= 29; i++) set_row(i, 1'b0, 5'b11110, 1'b1, EI, EI);
        set_row(26, 1'b0, 5'b11110, 1'b1, ED, ED);   // right vs pending fall: fall first
        set_row(31, 1'b0, 5'b11110, 1'b1, ER, ER);   // right after passing through RUN
        set_row(34, 1'b0, 5'b11111, 1'b0, EG, EG);   // fall on bottom row -> landed
        set_row(36, 1'b0, 5'b11011, 1'b0, EI, EI);   // down on bottom row ignored
        set_row(38, 1'b0, 5'b11011, 1'b1, ED, ED);   // user down, restarts gravity
        set_row(47, 1'b0, 5'b11111, 1'b1, ED, ED);   // fall 8 edges after the down
        for (int i = 49; i <= 61; i++) set_row(i, 1'b0, 5'b11101, 1'b1, EI, EI);
        set_row(49, 1'b0, 5'b11101, 1'b1, EL, EL);
        set_row(54, 1'b0, 5'b11101, 1'b1, EI, EL);   // first repeat
        set_row(55, 1'b0, 5'b11101, 1'b1, ED, EI);
        set_row(56, 1'b0, 5'b11101, 1'b1, EI, ED);
        set_row(61, 1'b0, 5'b11101, 1'b1, EI, EL);   // second repeat
        set_row(63, 1'b0, 5'b11111, 1'b1, ED, ED);
        set_row(65, 1'b0, 5'b10111, 1'b1, EU, EU);
        set_row(66, 1'b1, 5'b10111, 1'b1, EI, EI);   // reset during CMD
        set_row(67, 1'b0, 5'b10101, 1'b1, EI, EI);   // idle ignores moves
        set_row(68, 1'b0, 5'b11011, 1'b1, EI, EI);
        set_row(70, 1'b0, 5'b01111, 1'b1, EC, EC);
        set_row(79, 1'b0, 5'b11111, 1'b1, ED, ED);   // gravity restarted from reset

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].rst, tbl[i].btn, tbl[i].bot);
`ifdef SC_MOVESCHEDULER_AUTOREPEAT_EN
            e = tbl[i].exp_rep;
`else
            e = tbl[i].exp;
`endif
            check($sformatf("row%0d", i), want_of(e));
        end

        // Start held several cycles from RUN: one clear only, then release back to RUN.
        step(1'b0, 5'b11111, 1'b1); check("cmd_exit", want_of(EI));
        step(1'b0, 5'b01111, 1'b1); check("start_hold_clear", want_of(EC));
        step(1'b0, 5'b01111, 1'b1); check("start_hold_1", want_of(EI));
        step(1'b0, 5'b01111, 1'b1); check("start_hold_2", want_of(EI));
        step(1'b0, 5'b01111, 1'b1); check("start_hold_3", want_of(EI));
        step(1'b0, 5'b01111, 1'b1); check("start_hold_4", want_of(EI));
        step(1'b0, 5'b11111, 1'b1); check("start_release", want_of(EI));
        step(1'b0, 5'b11101, 1'b1); check("left_after_run", want_of(EL));
        step(1'b0, 5'b11111, 1'b1); check("left_done", want_of(EI));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sc_movescheduler.md
Name: sc_movescheduler

Overview:
- Sequencer in front of the point datapath (clear / load0 / load1 / shiftselection). It turns raw active-low button levels plus a periodic gravity tick into single-cycle, mutually exclusive datapath commands.
- It arbitrates between user moves and the gravity fall, enforces press-and-release, and (optionally) auto-repeats held moves.
- It sits between the button debouncers and the point register / shifter datapath, replacing direct button decoding.

Parameters:
- FALL_PERIOD, 25000000, clock cycles between gravity ticks (0.5 s at 50 MHz); legal range ≥ 2.
- REPEAT_DELAY, 12500000, clock cycles a move button must be held before each auto-repeat; legal range ≥ 2.
- CNT_W, 25, counter width; must satisfy 2^CNT_W ≥ max(FALL_PERIOD, REPEAT_DELAY).

Ports:
- SC_MOVESCHEDULER_CLOCK_50  in  1  system clock.
- SC_MOVESCHEDULER_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_MOVESCHEDULER_startButton_InLow  in  1  start / restart request.
- SC_MOVESCHEDULER_upButton_InLow  in  1  up request.
- SC_MOVESCHEDULER_downButton_InLow  in  1  down request.
- SC_MOVESCHEDULER_leftButton_InLow  in  1  left request.
- SC_MOVESCHEDULER_rightButton_InLow  in  1  right request.
- SC_MOVESCHEDULER_bottomsidecomparator_InLow  in  1  0 = point is on the bottom row.
- SC_MOVESCHEDULER_clear_OutLow  out  1  clear point register.
- SC_MOVESCHEDULER_load0_OutLow  out  1  move up.
- SC_MOVESCHEDULER_load1_OutLow  out  1  move down.
- SC_MOVESCHEDULER_shiftselection_Out  out  2  11 hold, 01 left, 10 right.
- SC_MOVESCHEDULER_landed_OutHigh  out  1  one-cycle pulse: gravity tick consumed while on bottom.

Behaviour:
- Clock and reset:
  - One clock, SC_MOVESCHEDULER_CLOCK_50.
  - Reset is synchronous and active-high. It has priority over every other event, including mid-command.
  - Reset result: state IDLE, fall counter 0, repeat counter 0, fall_pending 0.
  - Reset output values: clear/load0/load1 = 1, shiftselection = 11, landed = 0.
- Outputs:
  - All outputs are registered Moore outputs decoded from state plus the latched command.
  - At most one command is active in any cycle. Each command lasts exactly 1 cycle.
- Latency: a request sampled at clock edge N in RUN produces its command during cycle N+1.
- States:
  - IDLE: only start is honoured; the fall counter is held at 0. start=0 → CMD(CLEAR).
  - RUN: evaluates requests every cycle in this priority order:
    - start → CLEAR.
    - fall_pending → FALL.
    - up → UP.
    - down, only if bottomside=1 → DOWN.
    - left → LEFT.
    - right → RIGHT.
    - otherwise stay in RUN.
    - Down pressed with bottomside=0 is ignored: no command, remain in RUN.
  - CMD: lasts one cycle. Command outputs:
    - CLEAR → clear=0.
    - UP → load0=0.
    - DOWN → load1=0.
    - LEFT → shift=01.
    - RIGHT → shift=10.
    - FALL → load1=0 if bottomside=1 at decision time, else no datapath command and landed=1.
    - Exit: if any button is still low → HOLD (repeat counter cleared), else → RUN.
  - HOLD:
    - fall_pending → CMD(FALL).
    - Else all buttons high → RUN.
    - Else handle auto-repeat (see Optional Feature).
    - start and up never repeat and must be released first.
- Fall counter:
  - Runs in RUN, CMD and HOLD.
  - At FALL_PERIOD-1 it wraps to 0 and sets fall_pending.
  - Cleared to 0 on CLEAR and on user DOWN, so a user down restarts the gravity interval.
- fall_pending:
  - Cleared in the cycle CMD(FALL) is entered.
  - If a tick and the clear occur in the same cycle, set wins, so no tick is lost.
- Simultaneous events: a gravity tick and a button press in the same cycle issue FALL first. The button then produces its command in the next eligible cycle, provided it is still held and reached through RUN.

Optional Feature:
- Macro: SC_MOVESCHEDULER_AUTOREPEAT_EN.
- Defined:
  - In HOLD, the repeat counter increments each cycle.
  - At REPEAT_DELAY-1 it re-evaluates down (if bottomside=1), then left, then right. The first one still held → CMD with that command, and the counter clears.
  - A fall entering CMD also clears the counter.
- Undefined:
  - The repeat counter is not built.
  - HOLD only waits for fall_pending or full release.

Decomposition:
- Shared package / include sc_movescheduler_pkg:
  - State encodings: IDLE, RUN, CMD, HOLD.
  - Command encodings: NONE, CLEAR, UP, DOWN, LEFT, RIGHT, FALL.
  - Shift codes: SHIFT_HOLD=2'b11, SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10.
- Sub-module sc_movescheduler_ticker:
  - Parameterised modulo counter with enable, sync clear, and sticky pending flag with set-wins.
  - Instantiated for the fall timer; also reused for the repeat timer.

Test Plan (FALL_PERIOD=8, REPEAT_DELAY=4, AUTOREPEAT_EN defined):
- Reset, then start low for 1 cycle → clear_OutLow=0 for exactly 1 cycle, 1 cycle later; no other output active.
- After start, all buttons idle for 20 cycles → load1_OutLow=0 pulses 8 cycles apart; no pulse before the 8th cycle after CLEAR.
- Left held low 12 cycles → shift=01 once, then repeat pulses every 4 cycles in HOLD. Release → RUN; up pressed again → load0=0 once, with no repeat.
- Bottomside=0, gravity tick → landed_OutHigh=1 for 1 cycle and load1 stays 1. Down pressed while bottomside=0 → no command.
- Right pressed in the same cycle as the fall tick → load1=0 first, then shift=10 one cycle later only after passing through RUN/HOLD rules; fall_pending returns to 0.
- RESET_InHigh asserted during a CMD cycle → next cycle all outputs inactive and state IDLE. Buttons other than start are ignored until start.
